finish_sequencer: RTL and testbench
===================================

Name: finish_sequencer

Overview:
- Central end-of-test controller for the self-checking test benches.
- Collects per-client completion (done) and failure (fail) reports from up to NUM_CLIENTS checker sub-blocks.
- Enforces a cycle watchdog and drains in-flight activity.
- Issues a single one-cycle finish pulse with a pass/fail/timeout verdict; that pulse is the only trigger for the bench's "All Finished" print and simulation finish.

Parameters:
NUM_CLIENTS, 4, number of reporting clients (1..32)
TIMEOUT, 1000, max cycles in RUN before a forced finish (>=2)
DRAIN_CYCLES, 2, cycles waited in DRAIN after the last done (0 = skip DRAIN)
CNT_W, 16, width of the cycle counter
ABORT_ON_FAIL, 0, 1 = first reported fail ends the test immediately

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start_i  input  1  pulse; begins a test run
done_i  input  NUM_CLIENTS  per-client completion pulse or level; sticky once seen
fail_i  input  NUM_CLIENTS  per-client fail flag; sampled only when the matching done_i is high
finish_o  output  1  one-cycle pulse at end of test
busy_o  output  1  high in RUN and DRAIN
pass_o  output  1  verdict; valid from the finish_o cycle until the next start
fail_o  output  1  at least one client failed
timeout_o  output  1  watchdog expired
first_fail_idx_o  output  max(1,$clog2(NUM_CLIENTS))  index of the first failing client
done_mask_o  output  NUM_CLIENTS  sticky done bits
cycle_cnt_o  output  CNT_W  cycles spent in RUN; saturates at all-ones

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is asynchronous and active-low on rst_n.
  - While rst_n is low, all outputs are 0, the state is IDLE and the counters are 0.
  - Reset asserted mid-run aborts immediately. No finish_o is produced.
- States: IDLE, RUN, DRAIN, FINISH, HOLD.
- IDLE:
  - start_i=1 moves to RUN on the next edge.
  - On that edge, done_mask, fail flag, timeout, cycle_cnt and first_fail_idx are cleared.
  - done_i and fail_i are ignored in IDLE.
- RUN:
  - cycle_cnt increments every cycle. The first RUN cycle shows cycle_cnt_o=0.
  - done_i[k]=1 sets done_mask[k].
  - If fail_i[k] is also 1, fail_o is set. first_fail_idx_o latches k only if no fail was recorded earlier.
  - On simultaneous fails, the lowest index wins.
  - done_i on an already-set bit is ignored, including its fail_i.
- Exits from RUN, in priority order:
  1. ABORT_ON_FAIL=1 and a new fail this cycle -> FINISH.
  2. All mask bits set, counting this cycle's done_i -> DRAIN, or -> FINISH when DRAIN_CYCLES=0.
  3. cycle_cnt == TIMEOUT-1 -> FINISH with timeout_o=1.
  - If the last done and the watchdog expiry land on the same cycle, done wins and timeout_o stays 0.
- DRAIN:
  - Down-counter loads DRAIN_CYCLES-1 on entry and counts to 0, then -> FINISH.
  - done_i and fail_i are still sampled. A late fail still sets fail_o, but ABORT_ON_FAIL has no effect in DRAIN.
  - The watchdog is frozen.
- FINISH (one cycle):
  - finish_o=1.
  - pass_o = !fail_o && !timeout_o.
  - Then -> HOLD.
- HOLD:
  - Verdict outputs are held.
  - start_i returns to RUN with the same clearing as IDLE->RUN.
- start_i is ignored in RUN, DRAIN and FINISH.
- busy_o = state in {RUN, DRAIN}.
- Latency: the last done in cycle N gives finish_o in cycle N+1+DRAIN_CYCLES.

Decomposition:
- Package finish_seq_pkg holds:
  - the state enum typedef;
  - the function idx_w(n) = max(1,$clog2(n));
  - the verdict struct typedef (pass, fail, timeout, idx).
- One sub-module, finish_seq_client_tracker: the sticky done mask plus lowest-index first-fail capture. It is purely per-client bookkeeping with a clear input.
- The FSM, watchdog and drain counter stay in the top module.

Test Plan:
1. Defaults; start, then done_i=4'b0001, 4'b0010, 4'b0100, 4'b1000 on consecutive cycles with fail_i=0 -> finish_o one cycle, 3 cycles after the last done; pass_o=1, fail_o=0, done_mask_o=4'hF.
2. Start; done_i=4'b1111 with fail_i=4'b0110 in the same cycle -> fail_o=1, first_fail_idx_o=1, pass_o=0, finish_o 3 cycles later.
3. Start; only clients 0..2 report done -> finish_o when cycle_cnt_o=999; timeout_o=1, pass_o=0, done_mask_o=4'b0111.
4. ABORT_ON_FAIL=1; start; at RUN cycle 5, done_i=4'b0100 with fail_i=4'b0100 -> finish_o on the next cycle; first_fail_idx_o=2, fail_o=1.
5. Start; last done arrives exactly on RUN cycle 999 -> timeout_o=0, DRAIN entered, pass_o=1.
6. rst_n low during DRAIN -> all outputs 0 immediately and no finish_o. After release, start plus a full done set -> normal pass, proving clean restart; also start pulse while busy_o=1 is ignored and cycle_cnt_o is not cleared.

Source files
------------

// File: rtl/finish_seq_pkg.sv
// Shared types and helpers for the end-of-test finish sequencer.
package finish_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FINISH,
    S_HOLD
  } state_e;

  // Widest client index supported (32 clients)
  localparam int IDX_MAX_W = 5;

  typedef struct packed {
    logic                 pass;
    logic                 fail;
    logic                 timeout;
    logic [IDX_MAX_W-1:0] idx;
  } verdict_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/finish_seq_client_tracker.sv
// Per-client bookkeeping: sticky done mask, any-fail flag and lowest-index
// first-fail capture. Only first-time dones (and their fail bits) count.
module finish_seq_client_tracker
  import finish_seq_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int IW          = idx_w(NUM_CLIENTS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   en_i,
  input  logic [NUM_CLIENTS-1:0] done_i,
  input  logic [NUM_CLIENTS-1:0] fail_i,
  output logic [NUM_CLIENTS-1:0] mask_o,
  output logic                   all_done_o,
  output logic                   new_fail_o,
  output logic                   fail_o,
  output logic [IW-1:0]          first_idx_o
);

  logic [NUM_CLIENTS-1:0] mask_q, mask_d, new_done, new_fail;
  logic                   fail_q, fail_d;
  logic [IW-1:0]          idx_q, idx_d, low_idx;

  always_comb begin
    new_done = en_i ? (done_i & ~mask_q) : '0;
    new_fail = new_done & fail_i;
    low_idx  = '0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      if (new_fail[k]) low_idx = IW'(k);
    end
    mask_d = mask_q | new_done;
    fail_d = fail_q | (|new_fail);
    idx_d  = idx_q;
    if (!fail_q && (|new_fail)) idx_d = low_idx;
    if (clr_i) begin
      mask_d = '0;
      fail_d = 1'b0;
      idx_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      fail_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      mask_q <= mask_d;
      fail_q <= fail_d;
      idx_q  <= idx_d;
    end
  end

  assign mask_o      = mask_q;
  assign all_done_o  = &(mask_q | new_done);
  assign new_fail_o  = |new_fail;
  assign fail_o      = fail_q;
  assign first_idx_o = idx_q;

endmodule

// File: rtl/finish_sequencer.sv
// End-of-test controller: collects client done/fail reports, runs a watchdog,
// drains after the last done and emits a single finish pulse with a verdict.
module finish_sequencer
  import finish_seq_pkg::*;
#(
  parameter int NUM_CLIENTS   = 4,
  parameter int TIMEOUT       = 1000,
  parameter int DRAIN_CYCLES  = 2,
  parameter int CNT_W         = 16,
  parameter int ABORT_ON_FAIL = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start_i,
  input  logic [NUM_CLIENTS-1:0]             done_i,
  input  logic [NUM_CLIENTS-1:0]             fail_i,
  output logic                               finish_o,
  output logic                               busy_o,
  output logic                               pass_o,
  output logic                               fail_o,
  output logic                               timeout_o,
  output logic [idx_w(NUM_CLIENTS)-1:0]      first_fail_idx_o,
  output logic [NUM_CLIENTS-1:0]             done_mask_o,
  output logic [CNT_W-1:0]                   cycle_cnt_o
);

  localparam int IW = idx_w(NUM_CLIENTS);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]    DRAIN_LOAD = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             to_q, to_d;
  logic             clr, en, all_done, new_fail, any_fail;
  logic [IW-1:0]    first_idx;
  verdict_t         verdict;

  finish_seq_client_tracker #(
    .NUM_CLIENTS(NUM_CLIENTS),
    .IW         (IW)
  ) u_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .en_i       (en),
    .done_i     (done_i),
    .fail_i     (fail_i),
    .mask_o     (done_mask_o),
    .all_done_o (all_done),
    .new_fail_o (new_fail),
    .fail_o     (any_fail),
    .first_idx_o(first_idx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    to_d    = to_q;
    clr     = 1'b0;
    en      = 1'b0;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (start_i) begin
          state_d = S_RUN;
          clr     = 1'b1;
          cnt_d   = '0;
          to_d    = 1'b0;
        end
      end
      S_RUN: begin
        en = 1'b1;
        if ((ABORT_ON_FAIL != 0) && new_fail) begin
          state_d = S_FINISH;
        end else if (all_done) begin
          state_d = (DRAIN_CYCLES == 0) ? S_FINISH : S_DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_FINISH;
          to_d    = 1'b1;
        end else if (cnt_q != '1) begin
          // Counter only advances while staying in RUN, so it reads the last RUN cycle index
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        en = 1'b1;
        if (drain_q == '0) state_d = S_FINISH;
        else               drain_d = drain_q - DW'(1);
      end
      S_FINISH: state_d = S_HOLD;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    verdict.pass    = ((state_q == S_FINISH) || (state_q == S_HOLD)) && !any_fail && !to_q;
    verdict.fail    = any_fail;
    verdict.timeout = to_q;
    verdict.idx     = IDX_MAX_W'(first_idx);
  end

  generate
    if (IW < IDX_MAX_W) begin : g_idx_pad
      logic unused_idx_hi;
      assign unused_idx_hi = ^verdict.idx[IDX_MAX_W-1:IW];
    end
  endgenerate

  assign finish_o         = (state_q == S_FINISH);
  assign busy_o           = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign pass_o           = verdict.pass;
  assign fail_o           = verdict.fail;
  assign timeout_o        = verdict.timeout;
  assign first_fail_idx_o = verdict.idx[IW-1:0];
  assign cycle_cnt_o      = cnt_q;

endmodule

// File: tb/tb_finish_sequencer.sv
// Directed bench: a per-cycle vector table for the basic pass/fail runs, then
// hand sequences for watchdog, abort, reset-in-drain and zero-drain corners.
module tb_finish_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sa = 1'b0, sb = 1'b0;
  logic [3:0]  da = '0, fa = '0, db = '0, fb = '0;
  logic        fin_a, busy_a, pass_a, fl_a, to_a;
  logic        fin_b, busy_b, pass_b, fl_b, to_b;
  logic [1:0]  idx_a, idx_b;
  logic [3:0]  mask_a, mask_b;
  logic [15:0] cnt_a, cnt_b;

  int n_chk = 0;
  int n_err = 0;

  finish_sequencer #(.NUM_CLIENTS(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(sa), .done_i(da), .fail_i(fa),
    .finish_o(fin_a), .busy_o(busy_a), .pass_o(pass_a), .fail_o(fl_a),
    .timeout_o(to_a), .first_fail_idx_o(idx_a), .done_mask_o(mask_a),
    .cycle_cnt_o(cnt_a)
  );

  finish_sequencer #(.NUM_CLIENTS(4), .DRAIN_CYCLES(0), .ABORT_ON_FAIL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(sb), .done_i(db), .fail_i(fb),
    .finish_o(fin_b), .busy_o(busy_b), .pass_o(pass_b), .fail_o(fl_b),
    .timeout_o(to_b), .first_fail_idx_o(idx_b), .done_mask_o(mask_b),
    .cycle_cnt_o(cnt_b)
  );

  typedef struct {
    logic        s;
    logic [3:0]  d, f;
    logic        fin, busy, pass, fl, to;
    logic [1:0]  idx;
    logic [3:0]  mask;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [26:0] snap_a();
    return {fin_a, busy_a, pass_a, fl_a, to_a, idx_a, mask_a, cnt_a};
  endfunction

  function automatic logic [26:0] snap_b();
    return {fin_b, busy_b, pass_b, fl_b, to_b, idx_b, mask_b, cnt_b};
  endfunction

  task automatic step_a(input logic s, input logic [3:0] d, input logic [3:0] f);
    @(negedge clk);
    sa = s; da = d; fa = f;
  endtask

  task automatic step_b(input logic s, input logic [3:0] d, input logic [3:0] f);
    @(negedge clk);
    sb = s; db = d; fb = f;
  endtask

  initial begin
    int n;
    logic hit;

    // s, d, f | fin busy pass fail to idx mask cnt  (outputs seen before the row's edge)
    tbl[0]  = '{1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 16'd0};
    tbl[1]  = '{1'b0, 4'h1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 16'd0};
    tbl[2]  = '{1'b0, 4'h2, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h1, 16'd1};
    tbl[3]  = '{1'b0, 4'h4, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h3, 16'd2};
    tbl[4]  = '{1'b0, 4'h8, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h7, 16'd3};
    tbl[5]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'hF, 16'd3};
    tbl[6]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'hF, 16'd3};
    tbl[7]  = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'hF, 16'd3};
    tbl[8]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'hF, 16'd3};
    tbl[9]  = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'hF, 16'd3};
    tbl[10] = '{1'b0, 4'hF, 4'h6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 16'd0};
    tbl[11] = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 4'hF, 16'd0};
    tbl[12] = '{1'b0, 4'h1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 4'hF, 16'd0};
    tbl[13] = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 4'hF, 16'd0};
    tbl[14] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 4'hF, 16'd0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_a", 64'(snap_a()), 64'd0);
    chk("reset_b", 64'(snap_b()), 64'd0);
    rst_n = 1'b1;

    // Runs 1 and 2: pass with staggered dones, then same-cycle fails
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d", i), 64'(snap_a()),
          64'({tbl[i].fin, tbl[i].busy, tbl[i].pass, tbl[i].fl, tbl[i].to,
               tbl[i].idx, tbl[i].mask, tbl[i].cnt}));
      sa = tbl[i].s; da = tbl[i].d; fa = tbl[i].f;
    end

    // Watchdog: clients 0..2 only
    step_a(1'b1, 4'h0, 4'h0);
    step_a(1'b0, 4'h7, 4'h0);
    chk("t3_first_cnt", 64'(cnt_a), 64'd0);
    hit = 1'b0;
    n = 0;
    for (int i = 1; i <= 1100 && !hit; i++) begin
      step_a(1'b0, 4'h0, 4'h0);
      if (fin_a) begin hit = 1'b1; n = i; end
    end
    chk("t3_finish_seen", 64'(hit), 64'd1);
    chk("t3_latency", 64'(n), 64'd1000);
    chk("t3_cnt", 64'(cnt_a), 64'd999);
    chk("t3_verdict", 64'({pass_a, fl_a, to_a, mask_a}), 64'({1'b0, 1'b0, 1'b1, 4'h7}));

    // Last done exactly on the watchdog cycle: done wins
    step_a(1'b1, 4'h0, 4'h0);
    step_a(1'b0, 4'h7, 4'h0);
    hit = 1'b0;
    for (int i = 0; i < 1100 && !hit; i++) begin
      @(negedge clk);
      if (cnt_a == 16'd999) hit = 1'b1;
      else begin sa = 1'b0; da = 4'h0; fa = 4'h0; end
    end
    chk("t5_reach_999", 64'(hit), 64'd1);
    chk("t5_busy_999", 64'(busy_a), 64'd1);
    da = 4'h8;
    step_a(1'b0, 4'h0, 4'h0);
    chk("t5_drain", 64'({fin_a, busy_a, to_a, cnt_a}), 64'({1'b0, 1'b1, 1'b0, 16'd999}));
    step_a(1'b0, 4'h0, 4'h0);
    step_a(1'b0, 4'h0, 4'h0);
    chk("t5_finish", 64'({fin_a, pass_a, fl_a, to_a, mask_a}),
        64'({1'b1, 1'b1, 1'b0, 1'b0, 4'hF}));

    // start while busy is ignored; reset during DRAIN aborts silently
    step_a(1'b1, 4'h0, 4'h0);
    step_a(1'b0, 4'h0, 4'h0);
    step_a(1'b0, 4'h0, 4'h0);
    step_a(1'b1, 4'h0, 4'h0);
    step_a(1'b0, 4'h0, 4'h0);
    chk("t6_start_ignored", 64'({busy_a, cnt_a}), 64'({1'b1, 16'd3}));
    step_a(1'b0, 4'hF, 4'h0);
    step_a(1'b0, 4'h0, 4'h0);
    chk("t6_in_drain", 64'({busy_a, fin_a}), 64'({1'b1, 1'b0}));
    #2 rst_n = 1'b0;
    #1 chk("t6_reset_async", 64'(snap_a()), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t6_reset_hold%0d", i), 64'(snap_a()), 64'd0);
    end
    rst_n = 1'b1;
    step_a(1'b1, 4'h0, 4'h0);
    step_a(1'b0, 4'hF, 4'h0);
    step_a(1'b0, 4'h0, 4'h0);
    step_a(1'b0, 4'h0, 4'h0);
    chk("t6_no_early_fin", 64'(fin_a), 64'd0);
    step_a(1'b0, 4'h0, 4'h0);
    chk("t6_restart_pass", 64'({fin_a, pass_a, fl_a, to_a, mask_a}),
        64'({1'b1, 1'b1, 1'b0, 1'b0, 4'hF}));

    // Abort on first fail at RUN cycle 5
    step_b(1'b1, 4'h0, 4'h0);
    repeat (5) step_b(1'b0, 4'h0, 4'h0);
    step_b(1'b0, 4'h4, 4'h4);
    chk("t4_cnt5", 64'({busy_b, cnt_b}), 64'({1'b1, 16'd5}));
    step_b(1'b0, 4'h0, 4'h0);
    chk("t4_abort", 64'(snap_b()),
        64'({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 4'h4, 16'd5}));
    step_b(1'b0, 4'h0, 4'h0);
    chk("t4_hold", 64'({fin_b, fl_b, idx_b}), 64'({1'b0, 1'b1, 2'd2}));

    // Repeat done carrying a fail is ignored; simultaneous fails pick lowest index
    step_b(1'b1, 4'h0, 4'h0);
    step_b(1'b0, 4'h1, 4'h0);
    step_b(1'b0, 4'h1, 4'h1);
    step_b(1'b0, 4'hA, 4'hA);
    chk("b_refail_ignored", 64'({busy_b, fl_b}), 64'({1'b1, 1'b0}));
    step_b(1'b0, 4'h0, 4'h0);
    chk("b_lowest_idx", 64'({fin_b, fl_b, idx_b, mask_b}), 64'({1'b1, 1'b1, 2'd1, 4'hB}));

    // Zero drain: finish the cycle after the last done
    step_b(1'b0, 4'h0, 4'h0);
    step_b(1'b1, 4'h0, 4'h0);
    step_b(1'b0, 4'hF, 4'h0);
    step_b(1'b0, 4'h0, 4'h0);
    chk("b_nodrain_pass", 64'({fin_b, pass_b, fl_b, to_b, mask_b}),
        64'({1'b1, 1'b1, 1'b0, 1'b0, 4'hF}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
